// File: rtl/rinse_cycle.sv
// Rinse stage of a washer controller: repeated fill/agitate/drain passes, a final spin,
// then a held rinse-complete flag. Sensor waits are bounded by timeouts that latch a fault.
module rinse_cycle #(
  parameter int AGITATE_TICKS = 300,
  parameter int REV_PERIOD    = 30,
  parameter int FILL_TIMEOUT  = 200,
  parameter int DRAIN_TIMEOUT = 200,
  parameter int SPIN_TICKS    = 150,
  parameter int NUM_RINSES    = 2
) (
  input  logic CLK,
  input  logic Reset,
  input  logic Start,
  input  logic WaterFull,
  input  logic WaterEmpty,
  output logic FillValve,
  output logic DrainValve,
  output logic MotorOn,
  output logic Reverse,
  output logic T2r,
  output logic Fault
);

  typedef enum logic [2:0] {IDLE, FILL, AGITATE, DRAIN, SPIN, DONE, FAULT} state_t;

  typedef struct packed {
    logic fill;
    logic drain;
    logic motor;
    logic rev;
    logic t2r;
    logic fault;
  } outs_t;

  localparam logic [9:0] FILL_LAST  = 10'(FILL_TIMEOUT - 1);
  localparam logic [9:0] AGIT_LAST  = 10'(AGITATE_TICKS - 1);
  localparam logic [9:0] DRAIN_LAST = 10'(DRAIN_TIMEOUT - 1);
  localparam logic [9:0] SPIN_LAST  = 10'(SPIN_TICKS - 1);
  localparam logic [9:0] REV_LAST   = 10'(REV_PERIOD - 1);
  localparam logic [2:0] RINSE_LAST = 3'(NUM_RINSES - 1);

  state_t     state, nxt;
  logic [9:0] phase;
  logic [9:0] rev_cnt;
  logic [2:0] rinse;
  logic       rinse_inc;
  outs_t      outs, outs_n;

  // Actuator pattern for the first cycle of a state; Reverse is patched in below for AGITATE.
  function automatic outs_t decode(input state_t s);
    outs_t o;
    o = '0;
    case (s)
      FILL:    o.fill  = 1'b1;
      AGITATE: o.motor = 1'b1;
      DRAIN:   o.drain = 1'b1;
      SPIN:    begin o.drain = 1'b1; o.motor = 1'b1; end
      DONE:    o.t2r   = 1'b1;
      FAULT:   o.fault = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    nxt       = state;
    rinse_inc = 1'b0;
    case (state)
      IDLE:    if (Start) nxt = FILL;
      FILL: begin
        if (!Start)                  nxt = IDLE;
        else if (WaterFull)          nxt = AGITATE;
        else if (phase == FILL_LAST) nxt = FAULT;
      end
      AGITATE: begin
        if (!Start)                  nxt = IDLE;
        else if (phase == AGIT_LAST) nxt = DRAIN;
      end
      DRAIN: begin
        if (!Start) nxt = IDLE;
        else if (WaterEmpty) begin
          if (rinse == RINSE_LAST) nxt = SPIN;
          else begin
            nxt       = FILL;
            rinse_inc = 1'b1;
          end
        end else if (phase == DRAIN_LAST) nxt = FAULT;
      end
      SPIN: begin
        if (!Start)                  nxt = IDLE;
        else if (phase == SPIN_LAST) nxt = DONE;
      end
      DONE, FAULT: if (!Start) nxt = IDLE;
      default:     nxt = IDLE;
    endcase

    // Direction flips after each full REV_PERIOD spent agitating; entry always starts forward.
    outs_n = decode(nxt);
    if (state == AGITATE && nxt == AGITATE)
      outs_n.rev = (rev_cnt == REV_LAST) ? !outs.rev : outs.rev;
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (Reset) begin
      state   <= IDLE;
      phase   <= '0;
      rev_cnt <= '0;
      rinse   <= '0;
      outs    <= '0;
    end else begin
      state <= nxt;
      outs  <= outs_n;

      // Saturating so a long dwell can never wrap back onto a terminal count.
      if (nxt != state)     phase <= '0;
      else if (phase != '1) phase <= phase + 10'd1;

      if (state == AGITATE && nxt == AGITATE && rev_cnt != REV_LAST)
        rev_cnt <= rev_cnt + 10'd1;
      else
        rev_cnt <= '0;

      if (state == IDLE)  rinse <= '0;
      else if (rinse_inc) rinse <= rinse + 3'd1;
    end
  end

  assign FillValve  = outs.fill;
  assign DrainValve = outs.drain;
  assign MotorOn    = outs.motor;
  assign Reverse    = outs.rev;
  assign T2r        = outs.t2r;
  assign Fault      = outs.fault;

endmodule

// File: tb/tb_rinse_cycle.sv
// Directed bench for rinse_cycle with short phase lengths; every cycle's outputs are
// compared as one packed word {FillValve,DrainValve,MotorOn,Reverse,T2r,Fault}.
module tb_rinse_cycle;

  logic clk = 1'b0;
  logic rst, start, wf, we;
  logic fill_v, drain_v, motor, rev, t2r, fault;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_FILL  = 6'b100000;
  localparam logic [5:0] O_DRAIN = 6'b010000;
  localparam logic [5:0] O_AGI   = 6'b001000;
  localparam logic [5:0] O_REV   = 6'b000100;
  localparam logic [5:0] O_SPIN  = 6'b011000;
  localparam logic [5:0] O_DONE  = 6'b000010;
  localparam logic [5:0] O_FAULT = 6'b000001;

  bit rev_pat [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  rinse_cycle #(
    .AGITATE_TICKS(8),
    .REV_PERIOD   (2),
    .FILL_TIMEOUT (10),
    .DRAIN_TIMEOUT(10),
    .SPIN_TICKS   (4),
    .NUM_RINSES   (2)
  ) dut (
    .CLK       (clk),
    .Reset     (rst),
    .Start     (start),
    .WaterFull (wf),
    .WaterEmpty(we),
    .FillValve (fill_v),
    .DrainValve(drain_v),
    .MotorOn   (motor),
    .Reverse   (rev),
    .T2r       (t2r),
    .Fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic [5:0] exp);
    check(tag, {2'b00, fill_v, drain_v, motor, rev, t2r, fault}, {2'b00, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in the first observed FILL cycle; ends having sampled WaterEmpty in DRAIN.
  task automatic run_pass(input string tag, input int fill_n, input int drain_n, input bit prefull);
    for (int i = 0; i < fill_n; i++) begin
      expect_outs({tag, "_fill"}, O_FILL);
      if (i == fill_n - 1) wf = 1'b1;
      tick();
    end
    if (!prefull) wf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_outs({tag, "_agi"}, O_AGI | (rev_pat[i] ? O_REV : 6'd0));
      tick();
    end
    for (int i = 0; i < drain_n; i++) begin
      expect_outs({tag, "_drain"}, O_DRAIN);
      if (i == drain_n - 1) we = 1'b1;
      tick();
    end
    we = 1'b0;
  endtask

  task automatic spin_done(input string tag);
    for (int i = 0; i < 4; i++) begin
      expect_outs({tag, "_spin"}, O_SPIN);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      expect_outs({tag, "_done"}, O_DONE);
      tick();
    end
    start = 1'b0;
    tick();
    expect_outs({tag, "_ack_idle"}, O_IDLE);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wf = 1'b0; we = 1'b0;
    tick(); tick();
    expect_outs("reset", O_IDLE);
    start = 1'b1;
    tick();
    expect_outs("reset_over_start", O_IDLE);
    rst = 1'b0;
    tick();

    // Nominal two-pass run
    run_pass("nom1", 3, 2, 1'b0);
    run_pass("nom2", 3, 2, 1'b0);
    spin_done("nom");
    tick();
    expect_outs("idle_stays", O_IDLE);

    // WaterEmpty on the same edge as the drain timeout
    start = 1'b1;
    tick();
    run_pass("tie1", 3, 10, 1'b0);
    run_pass("tie2", 3, 10, 1'b0);
    spin_done("tie");

    // Fill timeout
    start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      expect_outs("fto_fill", O_FILL);
      tick();
    end
    expect_outs("fto_fault", O_FAULT);
    tick();
    expect_outs("fto_fault_held", O_FAULT);
    start = 1'b0;
    tick();
    expect_outs("fto_ack_idle", O_IDLE);

    // Abort in the fifth agitate cycle
    start = 1'b1;
    tick();
    expect_outs("abt_fill", O_FILL);
    wf = 1'b1;
    tick();
    wf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_outs("abt_agi", O_AGI | (rev_pat[i] ? O_REV : 6'd0));
      if (i == 4) start = 1'b0;
      tick();
    end
    expect_outs("abt_idle", O_IDLE);
    tick();
    expect_outs("abt_idle_held", O_IDLE);

    // Pre-full tub, then reset in the middle of spin
    wf = 1'b1;
    start = 1'b1;
    tick();
    run_pass("pf1", 1, 2, 1'b1);
    run_pass("pf2", 1, 2, 1'b1);
    expect_outs("mr_spin1", O_SPIN);
    tick();
    expect_outs("mr_spin2", O_SPIN);
    rst = 1'b1;
    tick();
    expect_outs("mr_reset", O_IDLE);
    rst = 1'b0;
    tick();
    run_pass("mr1", 1, 2, 1'b1);
    run_pass("mr2", 1, 2, 1'b1);
    spin_done("mr");
    wf = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
